// File: rtl/switch_seq_loader.sv
// rtl/switch_seq_loader.sv - debounced load, latch switches, paced MSB-first serial shift-out
// Optional feature macro: REPEAT_EN (continuous replay of the latched pattern).
module switch_seq_loader #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int STEP_DIV        = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load,
  input  logic             pause_n,
  input  logic             out_ready,
  output logic             seq_bit,
  output logic             seq_valid,
  output logic             seq_last,
  output logic [WIDTH-1:0] seq_window,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(WIDTH + 1);
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int TM_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV + 1) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0]  TM_LAST  = TM_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Button path state
  logic [1:0]      sync_q;
  logic [DB_W-1:0] db_cnt_q;
  logic            db_level_q;
  logic            load_pulse_q;

  // Sequencer state
  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] window_q, window_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TM_W-1:0]  timer_q, timer_d;

  // Two-flop synchronizer for the asynchronous push-button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_load};
    end
  end

  // Debounce: the level only flips after DEBOUNCE_CYCLES consecutive differing samples;
  // a rising flip produces a single-cycle load pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_q     <= '0;
      db_level_q   <= 1'b0;
      load_pulse_q <= 1'b0;
    end else begin
      load_pulse_q <= 1'b0;
      if (sync_q[1] == db_level_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        db_cnt_q     <= '0;
        db_level_q   <= sync_q[1];
        load_pulse_q <= sync_q[1];
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  // FSM state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      window_q <= '0;
      idx_q    <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      window_q <= window_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
    end
  end

  // Next-state logic; everything holds while paused, which also drops load pulses
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    window_d = window_q;
    idx_d    = idx_q;
    timer_d  = timer_q;
    if (pause_n) begin
      case (state_q)
        S_IDLE: begin
          if (load_pulse_q) begin
            shreg_d  = sw;
            window_d = sw;
            idx_d    = '0;
            timer_d  = '0;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (timer_q == TM_LAST) begin
            timer_d = '0;
            state_d = S_SEND;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_SEND: begin
          if (out_ready) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            idx_d   = idx_q + 1'b1;
            timer_d = '0;
            state_d = (idx_q == IDX_LAST) ? S_DONE : S_WAIT;
          end
        end
        S_DONE: begin
`ifdef REPEAT_EN
          // Replay the latched window; a load arriving right now takes the new switches
          if (load_pulse_q) begin
            shreg_d  = sw;
            window_d = sw;
          end else begin
            shreg_d = window_q;
          end
          idx_d   = '0;
          timer_d = '0;
          state_d = S_WAIT;
`else
          state_d = S_IDLE;
`endif
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from registered state; out_ready never reaches an output
  always_comb begin
    seq_valid  = (state_q == S_SEND) && pause_n;
    seq_last   = (state_q == S_SEND) && pause_n && (idx_q == IDX_LAST);
    seq_bit    = shreg_q[WIDTH-1];
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE) && pause_n;
    seq_window = window_q;
  end

endmodule
